// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequences fetch PCs from reset, BTB predictions and backend redirects,
// tags each packet with a redirect epoch and keeps its prediction stable while stalled.
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          EPOCH_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid_i,
  input  logic [63:0]        redirect_pc_i,
  input  logic               halt_i,
  output logic               btb_req_valid_o,
  output logic [63:0]        btb_req_pc_o,
  input  logic               btb_pred_taken_i,
  input  logic [63:0]        btb_pred_target_i,
  output logic               fetch_valid_o,
  input  logic               fetch_ready_i,
  output logic [63:0]        fetch_pc_o,
  output logic               fetch_pred_taken_o,
  output logic [63:0]        fetch_pred_target_o,
  output logic [EPOCH_W-1:0] fetch_epoch_o,
  output logic [31:0]        fetch_count_o,
  output logic [1:0]         dbg_state
);

  // Handshake: a packet transfers on a cycle where fetch_valid_o and fetch_ready_i are both
  // high; once offered it holds pc, prediction and epoch until that cycle or a redirect.
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_BUBBLE, S_HALT} state_t;

  state_t               state_q, state_d;
  logic [63:0]          pc_q, pc_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 hold_taken_q, hold_taken_d;
  logic [63:0]          hold_target_q, hold_target_d;
  logic [31:0]          count_q, count_d;
  logic                 fire;
  logic                 sel_taken;
  logic [63:0]          sel_target;

  assign fetch_valid_o   = (state_q == S_RUN);
  assign btb_req_valid_o = (state_q == S_RUN);
  assign btb_req_pc_o    = pc_q;
  assign fetch_pc_o      = pc_q;
  assign fetch_epoch_o   = epoch_q;
  assign fetch_count_o   = count_q;
  assign dbg_state       = state_q;

  // Once a stall has started, the captured prediction wins over the live BTB answer.
  assign sel_taken  = hold_valid_q ? hold_taken_q  : btb_pred_taken_i;
  assign sel_target = hold_valid_q ? hold_target_q : btb_pred_target_i;

  assign fetch_pred_taken_o  = fetch_valid_o & sel_taken;
  assign fetch_pred_target_o = fetch_valid_o ? sel_target : 64'd0;

  assign fire = fetch_valid_o & fetch_ready_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    hold_valid_d  = hold_valid_q;
    hold_taken_d  = hold_taken_q;
    hold_target_d = hold_target_q;
    count_d       = fire ? count_q + 32'd1 : count_q;

    case (state_q)
      S_BOOT, S_BUBBLE, S_HALT: begin
        state_d = halt_i ? S_HALT : S_RUN;
      end
      S_RUN: begin
        if (fire) begin
          pc_d          = sel_target;
          hold_valid_d  = 1'b0;
          hold_taken_d  = 1'b0;
          hold_target_d = 64'd0;
          state_d       = halt_i ? S_HALT : S_RUN;
        end else if (!hold_valid_q) begin
          hold_valid_d  = 1'b1;
          hold_taken_d  = btb_pred_taken_i;
          hold_target_d = btb_pred_target_i;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // A redirect overrides everything above except the fire count.
    if (redirect_valid_i) begin
      pc_d          = {redirect_pc_i[63:2], 2'b00};
      epoch_d       = epoch_q + EPOCH_W'(1);
      hold_valid_d  = 1'b0;
      hold_taken_d  = 1'b0;
      hold_target_d = 64'd0;
      state_d       = S_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      epoch_q       <= '0;
      hold_valid_q  <= 1'b0;
      hold_taken_q  <= 1'b0;
      hold_target_q <= 64'd0;
      count_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      hold_valid_q  <= hold_valid_d;
      hold_taken_q  <= hold_taken_d;
      hold_target_q <= hold_target_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: per-cycle vector table plus packet scoreboard, with hand-written
// sequences for epoch wrap and asynchronous reset in the middle of a stall.
module tb_fetch_pc_gen;

  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] HIT_PC    = 64'h0000_0000_8000_0004;
  localparam logic [63:0] HIT_TGT   = 64'h0000_0000_8000_0100;
  localparam logic [63:0] FORCE_TGT = 64'h0000_0000_8000_0200;
  localparam int W = 69;

  logic        clk;
  logic        rst;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        halt_i;
  logic        btb_req_valid_o;
  logic [63:0] btb_req_pc_o;
  logic        btb_pred_taken_i;
  logic [63:0] btb_pred_target_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [63:0] fetch_pc_o;
  logic        fetch_pred_taken_o;
  logic [63:0] fetch_pred_target_o;
  logic [3:0]  fetch_epoch_o;
  logic [31:0] fetch_count_o;
  logic [1:0]  dbg_state;

  logic        btb_hit_en;
  logic        btb_force;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  fetch_pc_gen #(.RESET_PC(RESET_PC), .EPOCH_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .redirect_valid_i    (redirect_valid_i),
    .redirect_pc_i       (redirect_pc_i),
    .halt_i              (halt_i),
    .btb_req_valid_o     (btb_req_valid_o),
    .btb_req_pc_o        (btb_req_pc_o),
    .btb_pred_taken_i    (btb_pred_taken_i),
    .btb_pred_target_i   (btb_pred_target_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_ready_i       (fetch_ready_i),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_pred_taken_o  (fetch_pred_taken_o),
    .fetch_pred_target_o (fetch_pred_target_o),
    .fetch_epoch_o       (fetch_epoch_o),
    .fetch_count_o       (fetch_count_o),
    .dbg_state           (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BTB model: one hit entry, a forced-target mode, otherwise PC+4.
  always_comb begin
    btb_pred_taken_i  = 1'b0;
    btb_pred_target_i = btb_req_pc_o + 64'd4;
    if (btb_force) begin
      btb_pred_target_i = FORCE_TGT;
    end else if (btb_hit_en && btb_req_pc_o == HIT_PC) begin
      btb_pred_taken_i  = 1'b1;
      btb_pred_target_i = HIT_TGT;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted packet pops one expected {pc, epoch, taken}.
  always @(negedge clk) begin
    if (!rst && fetch_valid_o && fetch_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no packet", fetch_pc_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("sb_packet", 64'({fetch_pc_o, fetch_epoch_o, fetch_pred_taken_o}), 64'(e));
        chk("sb_pc", fetch_pc_o, e[W-1:5]);
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        halt;
    logic        redir;
    logic [63:0] rpc;
    logic        hit;
    logic        frc;
    logic        ev;
    logic [63:0] epc;
    logic [3:0]  eep;
    logic        et;
    logic [63:0] etgt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic ready, logic halt, logic redir, logic [63:0] rpc,
                              logic hit, logic frc, logic ev, logic [63:0] epc,
                              logic [3:0] eep, logic et, logic [63:0] etgt, logic [31:0] ecnt);
    vec_t v;
    v.ready = ready; v.halt = halt; v.redir = redir; v.rpc = rpc; v.hit = hit; v.frc = frc;
    v.ev = ev; v.epc = epc; v.eep = eep; v.et = et; v.etgt = etgt; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check_outputs(input logic ev, input logic [63:0] epc, input logic [3:0] eep,
                               input logic et, input logic [63:0] etgt, input logic [31:0] ecnt);
    chk("fetch_valid", 64'(fetch_valid_o), 64'(ev));
    chk("btb_req_valid", 64'(btb_req_valid_o), 64'(ev));
    chk("fetch_pc", fetch_pc_o, epc);
    chk("btb_req_pc", btb_req_pc_o, epc);
    chk("epoch", 64'(fetch_epoch_o), 64'(eep));
    chk("pred_taken", 64'(fetch_pred_taken_o), 64'(et));
    chk("pred_target", fetch_pred_target_o, etgt);
    chk("count", 64'(fetch_count_o), 64'(ecnt));
  endtask

  logic [3:0]  ep_model;
  logic [63:0] rpc_last;

  initial begin
    rst = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 64'd0;
    halt_i = 1'b0;
    fetch_ready_i = 1'b1;
    btb_hit_en = 1'b0;
    btb_force = 1'b0;

    // Driver: ready, halt, redir, rpc, hit, force | valid, pc, epoch, taken, target, count
    vecs[0]  = mk(1,0,0,0,0,0, 0,64'h80000000,0,0,64'h0,0);
    vecs[1]  = mk(1,0,0,0,0,0, 1,64'h80000000,0,0,64'h80000004,0);
    vecs[2]  = mk(1,0,0,0,0,0, 1,64'h80000004,0,0,64'h80000008,1);
    vecs[3]  = mk(1,0,0,0,0,0, 1,64'h80000008,0,0,64'h8000000C,2);
    vecs[4]  = mk(1,0,1,64'h80000004,0,0, 1,64'h8000000C,0,0,64'h80000010,3);
    vecs[5]  = mk(1,0,0,0,1,0, 0,64'h80000004,1,0,64'h0,4);
    vecs[6]  = mk(1,0,0,0,1,0, 1,64'h80000004,1,1,64'h80000100,4);
    vecs[7]  = mk(1,0,0,0,0,0, 1,64'h80000100,1,0,64'h80000104,5);
    vecs[8]  = mk(0,0,0,0,0,0, 1,64'h80000104,1,0,64'h80000108,6);
    vecs[9]  = mk(0,0,0,0,0,1, 1,64'h80000104,1,0,64'h80000108,6);
    vecs[10] = mk(0,0,0,0,0,1, 1,64'h80000104,1,0,64'h80000108,6);
    vecs[11] = mk(1,0,0,0,0,1, 1,64'h80000104,1,0,64'h80000108,6);
    vecs[12] = mk(1,0,0,0,0,0, 1,64'h80000108,1,0,64'h8000010C,7);
    vecs[13] = mk(1,0,1,64'h1003,0,0, 1,64'h8000010C,1,0,64'h80000110,8);
    vecs[14] = mk(1,0,0,0,0,0, 0,64'h1000,2,0,64'h0,9);
    vecs[15] = mk(1,0,0,0,0,0, 1,64'h1000,2,0,64'h1004,9);
    vecs[16] = mk(0,1,0,0,0,0, 1,64'h1004,2,0,64'h1008,10);
    vecs[17] = mk(0,1,0,0,0,0, 1,64'h1004,2,0,64'h1008,10);
    vecs[18] = mk(1,1,0,0,0,0, 1,64'h1004,2,0,64'h1008,10);
    vecs[19] = mk(1,1,0,0,0,0, 0,64'h1008,2,0,64'h0,11);
    vecs[20] = mk(1,0,0,0,0,0, 0,64'h1008,2,0,64'h0,11);
    vecs[21] = mk(1,0,0,0,0,0, 1,64'h1008,2,0,64'h100C,11);
    vecs[22] = mk(1,1,0,0,0,0, 1,64'h100C,2,0,64'h1010,12);
    vecs[23] = mk(1,1,1,64'h2000,0,0, 0,64'h1010,2,0,64'h0,13);
    vecs[24] = mk(1,0,0,0,0,0, 0,64'h2000,3,0,64'h0,13);
    vecs[25] = mk(1,0,0,0,0,0, 1,64'h2000,3,0,64'h2004,13);
    vecs[26] = mk(0,0,1,64'h3000,0,0, 1,64'h2004,3,0,64'h2008,14);
    vecs[27] = mk(1,0,1,64'h4000,0,0, 0,64'h3000,4,0,64'h0,14);
    vecs[28] = mk(1,0,0,0,0,0, 0,64'h4000,5,0,64'h0,14);
    vecs[29] = mk(1,0,0,0,0,0, 1,64'h4000,5,0,64'h4004,14);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, RESET_PC, 4'd0, 1'b0, 64'd0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      fetch_ready_i    = vecs[i].ready;
      halt_i           = vecs[i].halt;
      redirect_valid_i = vecs[i].redir;
      redirect_pc_i    = vecs[i].rpc;
      btb_hit_en       = vecs[i].hit;
      btb_force        = vecs[i].frc;
      if (vecs[i].ready && vecs[i].ev) exp_q.push_back({vecs[i].epc, vecs[i].eep, vecs[i].et});
      @(negedge clk);
      check_outputs(vecs[i].ev, vecs[i].epc, vecs[i].eep, vecs[i].et, vecs[i].etgt, vecs[i].ecnt);
      @(posedge clk);
      #1;
    end
    btb_hit_en = 1'b0;
    btb_force = 1'b0;
    halt_i = 1'b0;

    // Back-to-back redirects: epoch increments every cycle and wraps through 0.
    ep_model = 4'd5;
    rpc_last = 64'd0;
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      redirect_valid_i = 1'b1;
      rpc_last = 64'h5000 + 64'(i * 16) + 64'($urandom_range(0, 3));
      redirect_pc_i = rpc_last;
      @(negedge clk);
      chk("wrap_epoch", 64'(fetch_epoch_o), 64'(ep_model));
      chk("wrap_count", 64'(fetch_count_o), 64'd15);
      @(posedge clk);
      #1;
      ep_model = ep_model + 4'd1;
    end
    redirect_valid_i = 1'b0;
    @(negedge clk);
    check_outputs(1'b0, {rpc_last[63:2], 2'b00}, ep_model, 1'b0, 64'd0, 32'd15);
    @(posedge clk);
    #1;
    fetch_ready_i = 1'b1;
    exp_q.push_back({{rpc_last[63:2], 2'b00}, ep_model, 1'b0});
    @(negedge clk);
    chk("wrap_first_valid", 64'(fetch_valid_o), 64'd1);
    @(posedge clk);
    #1;

    // Stall, then asynchronous reset between clock edges.
    fetch_ready_i = 1'b0;
    @(negedge clk);
    chk("stall_pc", fetch_pc_o, {rpc_last[63:2], 2'b00} + 64'd4);
    chk("stall_valid", 64'(fetch_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs(1'b0, RESET_PC, 4'd0, 1'b0, 64'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fetch_ready_i = 1'b1;
    @(negedge clk);
    check_outputs(1'b0, RESET_PC, 4'd0, 1'b0, 64'd0, 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back({RESET_PC, 4'd0, 1'b0});
    @(negedge clk);
    check_outputs(1'b1, RESET_PC, 4'd0, 1'b0, RESET_PC + 64'd4, 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back({RESET_PC + 64'd4, 4'd0, 1'b0});
    @(negedge clk);
    check_outputs(1'b1, RESET_PC + 64'd4, 4'd0, 1'b0, RESET_PC + 64'd8, 32'd1);
    @(posedge clk);
    #1;
    fetch_ready_i = 1'b0;
    @(negedge clk);
    chk("final_count", 64'(fetch_count_o), 64'd2);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, first fetch PC after reset.
REQ-002 Parameter: EPOCH_W, default 4, width of the redirect epoch tag.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 redirect_valid_i  in  1  backend redirect (mispredict/exception), highest priority.
REQ-006 redirect_pc_i  in  64  redirect target PC.
REQ-007 halt_i  in  1  backend halt request; fetch paused while high.
REQ-008 btb_req_valid_o  out  1  BTB lookup valid.
REQ-009 btb_req_pc_o  out  64  BTB lookup PC.
REQ-010 btb_pred_taken_i  in  1  BTB hit/taken, combinational from btb_req_pc_o.
REQ-011 btb_pred_target_i  in  64  BTB next PC (target on hit, PC+4 on miss).
REQ-012 fetch_valid_o  out  1  fetch packet valid to I-cache/decode.
REQ-013 fetch_ready_i  in  1  downstream accepts packet.
REQ-014 fetch_pc_o  out  64  packet PC.
REQ-015 fetch_pred_taken_o  out  1  prediction attached to packet.
REQ-016 fetch_pred_target_o  out  64  predicted next PC attached to packet.
REQ-017 fetch_epoch_o  out  EPOCH_W  epoch of packet.
REQ-018 fetch_count_o  out  32  count of accepted packets.

Function
REQ-019 FSM states: BOOT, RUN, BUBBLE, HALT; encoding free.
REQ-020 BOOT: entered on reset, lasts exactly one cycle, fetch_valid_o=0, then RUN (or HALT if halt_i=1, or BUBBLE on redirect).
REQ-021 RUN: fetch_valid_o=1, btb_req_valid_o=1, btb_req_pc_o=fetch_pc_o=pc_q.
REQ-022 Fire = fetch_valid_o & fetch_ready_i; on fire without redirect, pc_q <= packet predicted target, fetch_count_o += 1 (wraps mod 2^32).
REQ-023 Prediction stability: in first cycle a packet is offered and not fired, BTB outputs captured in hold register; fetch_pred_* shall then show held values until fire/redirect; BTB lookup PC stays pc_q.
REQ-024 While fetch_valid_o=1 and fetch_ready_i=0, fetch_pc_o, fetch_pred_*, fetch_epoch_o shall not change.
REQ-025 Redirect (any state, any cycle): pc_q <= {redirect_pc_i[63:2], 2'b00}, epoch += 1 (wraps mod 2^EPOCH_W), hold register cleared, next state BUBBLE; a same-cycle fire still counts but its predicted target is discarded.
REQ-026 BUBBLE: exactly one cycle, fetch_valid_o=0, btb_req_valid_o=0; then RUN, or HALT if halt_i=1.
REQ-027 halt_i=1 in RUN: a currently offered but unfired packet stays valid until fire, then HALT; if fired same cycle, pc_q advances, then HALT.
REQ-028 HALT: fetch_valid_o=0, pc_q and epoch held; halt_i=0 -> RUN next cycle; redirect -> BUBBLE.
REQ-029 Redirect has priority over halt_i and fire in every state.
REQ-030 fetch_valid_o, btb_req_valid_o are functions of registered state only (no combinational path from fetch_ready_i).
REQ-031 Latency: RUN with fetch_ready_i=1 continuously yields one packet per cycle; redirect to first redirected packet = 2 cycles.

Reset
REQ-032 rst=1 asynchronously forces: state BOOT, pc_q=RESET_PC, epoch=0, hold cleared, fetch_count_o=0, fetch_valid_o=0, btb_req_valid_o=0.
REQ-033 Reset mid-operation discards any offered packet; no fire counted in the reset cycle.
REQ-034 fetch_pc_o shows pc_q in all states; fetch_pred_* = 0 when fetch_valid_o=0.

Verification
REQ-035 Release reset, ready=1, BTB miss (target=PC+4): packets at 0x8000_0000, _0004, _0008 on cycles 2,3,4; count=3.
REQ-036 BTB hit on 0x8000_0004 target 0x8000_0100, ready=1: next packet PC 0x8000_0100, fetch_pred_taken_o=1 on the 0x..04 packet.
REQ-037 ready=0 for 3 cycles while BTB target changes from 0x..08 to 0x..200: packet fields unchanged, after ready=1 next PC 0x..08.
REQ-038 Redirect to 0x1003 in RUN with fire same cycle: one bubble cycle, next packet PC 0x1000, epoch 0->1, count includes fired packet; 16 redirects wrap epoch to 0.
REQ-039 halt_i=1 with ready=0: packet held until ready=1, then HALT with valid=0; halt_i=0 -> packet at advanced PC next cycle.
REQ-040 Assert rst asynchronously mid-stall: outputs reset immediately without a clock edge; fetch restarts at RESET_PC with epoch 0, count 0.
